// File: rtl/shared_ram_arbiter_pkg.sv
// Shared definitions for the shared RAM arbiter slice.
//   - clog2 helper for index widths
//   - IDLE/RESP response-state encoding
//   - slice_field: extracts requester k's field from a flat packed bus
package shared_ram_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  // Upper bounds for the generic slicing helper; callers zero-extend into
  // FLAT_MAX and truncate the FIELD_MAX result to the real field width.
  localparam int unsigned FLAT_MAX  = 256;
  localparam int unsigned FIELD_MAX = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [FIELD_MAX-1:0] slice_field(
    input logic [FLAT_MAX-1:0] flat,
    input int unsigned         idx,
    input int unsigned         width
  );
    logic [FLAT_MAX-1:0]  shifted;
    logic [FIELD_MAX-1:0] mask;
    shifted = flat >> (idx * width);
    mask    = '0;
    for (int unsigned b = 0; b < FIELD_MAX; b++) begin
      if (b < width) mask[b] = 1'b1;
    end
    return shifted[FIELD_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/shared_ram_arbiter_if.sv
// Request/response bus between REQ_CNT requesters and the shared RAM arbiter.
//   master: requester side (drives requests, accepts responses)
//   slave : arbiter side (grants requests, presents read responses)
interface shared_ram_arbiter_if #(
  parameter int unsigned REQ_CNT    = 2,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [REQ_CNT-1:0]            req_vld;
  logic [REQ_CNT-1:0]            req_rdy;
  logic [REQ_CNT-1:0]            req_we;
  logic [REQ_CNT*ADDR_WIDTH-1:0] req_addr;
  logic [REQ_CNT*DATA_WIDTH-1:0] req_wdata;
  logic                          resp_vld;
  logic                          resp_rdy;
  logic [ID_WIDTH-1:0]           resp_id;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_err;

  modport master (
    output req_vld, req_we, req_addr, req_wdata, resp_rdy,
    input  req_rdy, resp_vld, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_vld, req_we, req_addr, req_wdata, resp_rdy,
    output req_rdy, resp_vld, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/shared_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   req_i      : per-requester request
//   en_i       : grant enable; no grant and pointer holds when low
//   gnt_o      : one-hot grant (combinational from req_i)
//   gnt_idx_o  : index of the granted requester
module rr_arbiter
  import shared_ram_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQ_CNT-1:0]          req_i,
  input  logic                        en_i,
  output logic [REQ_CNT-1:0]          gnt_o,
  output logic [clog2(REQ_CNT)-1:0]   gnt_idx_o
);
  localparam int unsigned IDX_W = clog2(REQ_CNT);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [REQ_CNT-1:0] cand_oh;
  logic               found;
  int unsigned        cand;

  // Walk from the pointer, wrapping modulo REQ_CNT; first requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    ptr_d     = ptr_q;
    found     = 1'b0;
    cand      = 0;
    cand_oh   = '0;
    if (en_i) begin
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
        cand    = (32'(ptr_q) + i) % REQ_CNT;
        cand_oh = REQ_CNT'(1) << cand;
        if (!found && |(req_i & cand_oh)) begin
          gnt_o     = cand_oh;
          gnt_idx_o = IDX_W'(cand);
          ptr_d     = IDX_W'((cand + 1) % REQ_CNT);
          found     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/shared_ram_arbiter.sv
// Shares one single-port byte RAM between REQ_CNT requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of shared_ram_arbiter_if (requests in, grants and
//              tagged read responses out)
module shared_ram_arbiter
  import shared_ram_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT    = 2,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 5
) (
  input  logic                clk,
  input  logic                rst,
  shared_ram_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = clog2(REQ_CNT);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  logic                  resp_vld;
  logic                  can_issue;
  logic [REQ_CNT-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any, sel_we, in_range, rd_grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, rd_data;

  assign resp_vld  = (state_q == ST_RESP);
  // No grants while in reset so a reset cycle cannot write the RAM.
  assign can_issue = (!resp_vld || bus.resp_rdy) && !rst;

  rr_arbiter #(.REQ_CNT(REQ_CNT)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.req_vld),
    .en_i      (can_issue),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign bus.req_rdy = gnt;
  assign gnt_any     = |gnt;
  assign sel_we      = |(bus.req_we & gnt);
  assign rd_grant    = gnt_any && !sel_we;

  always_comb begin
    sel_addr  = ADDR_WIDTH'(slice_field(FLAT_MAX'(bus.req_addr), 32'(gnt_idx), ADDR_WIDTH));
    sel_wdata = DATA_WIDTH'(slice_field(FLAT_MAX'(bus.req_wdata), 32'(gnt_idx), DATA_WIDTH));
    in_range  = 32'(sel_addr) < RAM_DEPTH;
    // Out-of-range addresses match no word and read back as zero.
    rd_data   = '0;
    for (int unsigned w = 0; w < RAM_DEPTH; w++) begin
      if (32'(sel_addr) == w) rd_data = mem_q[w];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < RAM_DEPTH; w++) begin
      if (gnt_any && sel_we && 32'(sel_addr) == w) mem_q[w] <= sel_wdata;
    end
  end

  // A new read grant overrides acceptance, giving back-to-back responses.
  always_comb begin
    state_d     = state_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    if (rd_grant) begin
      state_d     = ST_RESP;
      resp_id_d   = ID_WIDTH'(gnt_idx);
      resp_data_d = rd_data;
      resp_err_d  = !in_range;
    end else if (bus.resp_rdy) begin
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign bus.resp_vld  = resp_vld;
  assign bus.resp_id   = resp_id_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;
endmodule

// File: tb/tb_shared_ram_arbiter.sv
module tb_shared_ram_arbiter;
  localparam int N     = 2;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 5;

  logic clk, rst;
  shared_ram_arbiter_if #(.REQ_CNT(N), .ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  shared_ram_arbiter #(
    .REQ_CNT(N), .ID_WIDTH(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int id; int data; int err; } resp_t;

  resp_t       sb[$];
  int          ref_mem[DEPTH];
  int          ptr;
  logic [N-1:0] last_gnt;
  bit          started;
  int          n_cmp, n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int k, input bit vld, input bit we, input int addr, input int wdata);
    bus.req_vld[k]              = vld;
    bus.req_we[k]               = we;
    bus.req_addr[k*AW +: AW]    = AW'(addr);
    bus.req_wdata[k*DW +: DW]   = DW'(wdata);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluated mid-cycle once inputs are settled. Decides the
  // winner from the rotating priority rule, applies writes to its own memory
  // and queues the response each read must produce one cycle later.
  initial begin
    ptr = 0;
    last_gnt = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        ptr = 0;
        sb.delete();
        last_gnt = '0;
      end else begin
        automatic int winner = -1;
        automatic logic [N-1:0] exp_gnt = '0;
        automatic bit can = (sb.size() == 0) || bus.resp_rdy;
        if (can) begin
          for (int i = 0; i < N; i++) begin
            automatic int k = (ptr + i) % N;
            if (winner < 0 && bus.req_vld[k]) winner = k;
          end
        end
        if (winner >= 0) exp_gnt[winner] = 1'b1;
        if (started) check("req_rdy", 32'(bus.req_rdy), 32'(exp_gnt));
        last_gnt = exp_gnt;
        if (winner >= 0) begin
          automatic int a = int'(bus.req_addr[winner*AW +: AW]);
          ptr = (winner + 1) % N;
          if (bus.req_we[winner]) begin
            if (a < DEPTH) ref_mem[a] = int'(bus.req_wdata[winner*DW +: DW]);
          end else begin
            automatic resp_t r;
            r.id   = winner;
            r.err  = (a >= DEPTH) ? 1 : 0;
            r.data = (a >= DEPTH) ? 0 : ref_mem[a];
            sb.push_back(r);
          end
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head and
  // retires it on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (started && !rst) begin
        check("resp_vld", 32'(bus.resp_vld), 32'(sb.size() != 0));
        if (bus.resp_vld && sb.size() > 0) begin
          check("resp_id",   32'(bus.resp_id),   32'(sb[0].id));
          check("resp_data", 32'(bus.resp_data), 32'(sb[0].data));
          check("resp_err",  32'(bus.resp_err),  32'(sb[0].err));
          if (bus.resp_rdy) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    started = 1'b0;
    rst = 1'b1;
    bus.req_vld = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_resp_vld",  32'(bus.resp_vld),  0);
    check("reset_resp_id",   32'(bus.resp_id),   0);
    check("reset_resp_data", 32'(bus.resp_data), 0);
    check("reset_resp_err",  32'(bus.resp_err),  0);
    started = 1'b1;
    tick();

    // Fairness straight after reset: both reading, grants 0,1,0,1...
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 3, 0);
    repeat (6) tick();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();

    // Fill every word so later reads have known contents.
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 1, 1, a, a * 17 + 3);
      tick();
    end

    // Single write then read.
    drive(0, 1, 1, 2, 8'h5A); tick();
    drive(0, 1, 0, 2, 0);     tick();
    drive(0, 0, 0, 0, 0);     tick();

    // Backpressure: response held 3 cycles, req0 keeps requesting.
    bus.resp_rdy = 1'b0;
    drive(0, 1, 0, 1, 0); tick();
    drive(0, 1, 0, 3, 0); repeat (3) tick();
    bus.resp_rdy = 1'b1;  tick();
    drive(0, 0, 0, 0, 0); tick();

    // Out-of-range write then read, then sweep the valid words.
    drive(0, 1, 1, 6, 8'hFF); tick();
    drive(0, 1, 0, 6, 0);     tick();
    drive(0, 1, 0, 7, 0);     tick();
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 1, 0, a, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);

    // Write by req1 followed immediately by read from req0.
    drive(1, 1, 1, 4, 8'h33); tick();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 4, 0);     tick();
    drive(0, 0, 0, 0, 0);     tick();

    // Reset while a response is stalled.
    bus.resp_rdy = 1'b0;
    drive(0, 1, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    rst = 1'b1;
    drive(0, 1, 0, 2, 0);
    drive(1, 1, 0, 3, 0);
    tick();
    rst = 1'b0;
    bus.resp_rdy = 1'b1;
    repeat (4) tick();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();

    // Randomised traffic; a pending ungranted request is held unchanged
    // (or occasionally withdrawn).
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!(bus.req_vld[k] && !last_gnt[k] && $urandom_range(0, 9) != 0)) begin
          drive(k, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), $urandom_range(0, 255));
        end
      end
      bus.resp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    bus.resp_rdy = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    #3;
    check("drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
